// File: rtl/sisc_ctrl_p_if.sv
// Control interface between the SISC multi-cycle controller and its datapath.
//   opcode, mm, stat, mem_rdy : IR fields, ALU flags and data-memory ready (into the controller)
//   pc_*, br_sel, ir_load     : PC / IR controls
//   rf_we, wb_sel, rd_sel     : register-file controls
//   alu_op                    : 00 reg-reg, 01 immediate, 10 address add
//   dm_re, dm_we              : data-memory strobes
//   halted, mem_err, state    : status / debug
// Modport master is the controller; modport slave is the datapath side.
interface sisc_ctrl_p_if #(
  parameter int unsigned OP_W = 4,
  parameter int unsigned MM_W = 4
);
  logic [OP_W-1:0] opcode;
  logic [MM_W-1:0] mm;
  logic [MM_W-1:0] stat;
  logic            mem_rdy;
  logic            pc_rst;
  logic            pc_write;
  logic            pc_sel;
  logic            br_sel;
  logic            ir_load;
  logic            rf_we;
  logic            wb_sel;
  logic            rd_sel;
  logic [1:0]      alu_op;
  logic            dm_re;
  logic            dm_we;
  logic            halted;
  logic            mem_err;
  logic [2:0]      state;

  modport master (
    input  opcode, mm, stat, mem_rdy,
    output pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel, rd_sel,
    output alu_op, dm_re, dm_we, halted, mem_err, state
  );

  modport slave (
    output opcode, mm, stat, mem_rdy,
    input  pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel, rd_sel,
    input  alu_op, dm_re, dm_we, halted, mem_err, state
  );
endinterface

// File: rtl/sisc_ctrl_p.sv
// SISC multi-cycle control FSM: START0/START1/FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT.
// Ports:
//   clk   : system clock, rising edge
//   rst_f : asynchronous active-low reset
//   bus   : sisc_ctrl_p_if.master (IR fields, ALU flags, mem_rdy in; control strobes out)
// Outputs are combinational in present state, opcode, mm and stat.
// Optional feature: define SISC_CTRL_MEM_WAIT_EN to make MEM wait for mem_rdy on LOD/STR,
// with a TO_W-bit timeout that sets the sticky mem_err flag and halts.
module sisc_ctrl_p #(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned MM_W   = 4,
  parameter int unsigned AM_IMM = 8,
  parameter int unsigned TO_W   = 4
) (
  input logic          clk,
  input logic          rst_f,
  sisc_ctrl_p_if.master bus
);

  typedef enum logic [2:0] {
    StStart0    = 3'd0,
    StStart1    = 3'd1,
    StFetch     = 3'd2,
    StDecode    = 3'd3,
    StExecute   = 3'd4,
    StMem       = 3'd5,
    StWriteback = 3'd6,
    StHalt      = 3'd7
  } state_e;

  localparam logic [OP_W-1:0] OpLod = OP_W'(1);
  localparam logic [OP_W-1:0] OpStr = OP_W'(2);
  localparam logic [OP_W-1:0] OpBra = OP_W'(4);
  localparam logic [OP_W-1:0] OpBrr = OP_W'(5);
  localparam logic [OP_W-1:0] OpBne = OP_W'(6);
  localparam logic [OP_W-1:0] OpAlu = OP_W'(8);
  localparam logic [OP_W-1:0] OpHlt = OP_W'(15);
  localparam logic [MM_W-1:0] MmImm = MM_W'(AM_IMM);

  state_e state_q, state_d;

  logic is_lod, is_str, is_bra, is_brr, is_bne, is_alu, is_hlt;
  logic br_taken;
  logic [1:0] alu_code;

  assign is_lod = (bus.opcode == OpLod);
  assign is_str = (bus.opcode == OpStr);
  assign is_bra = (bus.opcode == OpBra);
  assign is_brr = (bus.opcode == OpBrr);
  assign is_bne = (bus.opcode == OpBne);
  assign is_alu = (bus.opcode == OpAlu);
  assign is_hlt = (bus.opcode == OpHlt);

  // BRA/BRR with mm==0 are unconditional; BNE is taken when no selected flag is set.
  always_comb begin
    br_taken = 1'b0;
    if (is_bra || is_brr) begin
      br_taken = (bus.mm == '0) || ((bus.mm & bus.stat) != '0);
    end else if (is_bne) begin
      br_taken = ((bus.mm & bus.stat) == '0);
    end
  end

  always_comb begin
    alu_code = 2'b00;
    if (is_alu) begin
      alu_code = (bus.mm == MmImm) ? 2'b01 : 2'b00;
    end else if (is_lod || is_str) begin
      alu_code = 2'b10;
    end
  end

`ifdef SISC_CTRL_MEM_WAIT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = bus.mem_rdy;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
`ifdef SISC_CTRL_MEM_WAIT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StStart0:    state_d = StStart1;
      StStart1:    state_d = StFetch;
      StFetch:     state_d = StDecode;
      StDecode:    state_d = is_hlt ? StHalt : StExecute;
      StExecute: begin
        state_d = StMem;
`ifdef SISC_CTRL_MEM_WAIT_EN
        cnt_d   = '0;
`endif
      end
      StMem: begin
`ifdef SISC_CTRL_MEM_WAIT_EN
        if (!(is_lod || is_str) || bus.mem_rdy) begin
          // mem_rdy wins over a coincident timeout
          state_d = StWriteback;
        end else if (cnt_q == '1) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = StWriteback;
`endif
      end
      StWriteback: state_d = StFetch;
      StHalt:      state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= StStart0;
`ifdef SISC_CTRL_MEM_WAIT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SISC_CTRL_MEM_WAIT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Output decode
  always_comb begin
    bus.pc_rst   = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.br_sel   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.rd_sel   = 1'b0;
    bus.alu_op   = 2'b00;
    bus.dm_re    = 1'b0;
    bus.dm_we    = 1'b0;
    bus.halted   = 1'b0;
    unique case (state_q)
      StStart0: bus.pc_rst = 1'b1;
      StStart1: ;
      StFetch: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
      end
      StDecode: ;
      StExecute: begin
        bus.alu_op = alu_code;
        if (br_taken) begin
          bus.pc_write = 1'b1;
          bus.pc_sel   = 1'b1;
          bus.br_sel   = !is_brr;
        end
      end
      StMem: begin
        if (is_lod || is_str) begin
          bus.alu_op = 2'b10;
          bus.dm_re  = is_lod;
          bus.dm_we  = is_str;
        end
      end
      StWriteback: begin
        if (is_alu) begin
          bus.rf_we  = 1'b1;
          bus.rd_sel = 1'b1;
          bus.alu_op = alu_code;
        end else if (is_lod) begin
          bus.rf_we  = 1'b1;
          bus.wb_sel = 1'b1;
          bus.rd_sel = 1'b1;
        end
      end
      StHalt: bus.halted = 1'b1;
    endcase
  end

  assign bus.state = state_q;
`ifdef SISC_CTRL_MEM_WAIT_EN
  assign bus.mem_err = err_q;
`else
  assign bus.mem_err = 1'b0;
`endif

endmodule
